axis_pkt_deframer: RTL and testbench

- Receive-side counterpart of the tlast-generating stream path: consumes a packetized AXI4-Stream (e.g. DMA MM2S output) carrying tlast, checks each packet's beat count against an expected length, and forwards the payload as a continuous, unframed stream.
- Sits between the DMA read channel and a downstream sample consumer. Beats beyond the expected length are dropped. Length errors are reported as pulses and counters.

---
 rtl/axis_pkt_deframer.sv | 159 +++++++++++++++
 tb/tb_axis_pkt_deframer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_deframer.sv
// Packet deframer: checks each AXI4-Stream packet's beat count against an expected
// length, forwards up to that many beats through a one-deep register slice and drops the rest.
module axis_pkt_deframer #(
  parameter  int TDATA_WIDTH    = 32,
  parameter  int MAX_PKT_LENGTH = 256,
  parameter  int ERR_CNT_WIDTH  = 16,
  localparam int CW             = $clog2(MAX_PKT_LENGTH) + 1
) (
  input  logic                     aclk,
  input  logic                     reset,
  input  logic [CW-1:0]            pkt_length,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [CW-1:0]            o_cnt,
  output logic                     pkt_done,
  output logic                     len_err,
  output logic [ERR_CNT_WIDTH-1:0] pkt_cnt,
  output logic [ERR_CNT_WIDTH-1:0] short_cnt,
  output logic [ERR_CNT_WIDTH-1:0] long_cnt
);

  localparam logic [CW-1:0] MAX_LEN = CW'(MAX_PKT_LENGTH);
  localparam logic [CW-1:0] ONE_LEN = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e                   state_q;
  logic [CW-1:0]            len_q;
  logic [CW-1:0]            cnt_q;
  logic                     m_valid_q;
  logic [TDATA_WIDTH-1:0]   m_data_q;
  logic                     pkt_done_q;
  logic                     len_err_q;
  logic [ERR_CNT_WIDTH-1:0] pkt_cnt_q;
  logic [ERR_CNT_WIDTH-1:0] short_cnt_q;
  logic [ERR_CNT_WIDTH-1:0] long_cnt_q;

  logic                     acc_d;
  logic [CW-1:0]            l_eff_d;
  logic [CW-1:0]            cnt_inc_d;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + ERR_CNT_WIDTH'(1);
    end
  endfunction

  // Dropped beats are always taken; otherwise only when the slice can accept a new beat.
  assign s_axis_tready = ~reset & ((state_q == S_DROP) | ~m_valid_q | m_axis_tready);

  // Handshake, next beat count and the clamped length for a packet starting this cycle.
  always_comb begin
    acc_d     = s_axis_tvalid & s_axis_tready;
    cnt_inc_d = cnt_q + ONE_LEN;
    if ((pkt_length == {CW{1'b0}}) || (pkt_length > MAX_LEN)) begin
      l_eff_d = MAX_LEN;
    end else begin
      l_eff_d = pkt_length;
    end
  end

  // Packet FSM, output slice, status pulses and statistics counters.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= {CW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      m_valid_q   <= 1'b0;
      m_data_q    <= {TDATA_WIDTH{1'b0}};
      pkt_done_q  <= 1'b0;
      len_err_q   <= 1'b0;
      pkt_cnt_q   <= {ERR_CNT_WIDTH{1'b0}};
      short_cnt_q <= {ERR_CNT_WIDTH{1'b0}};
      long_cnt_q  <= {ERR_CNT_WIDTH{1'b0}};
    end else begin
      pkt_done_q <= 1'b0;
      len_err_q  <= 1'b0;
      if (m_valid_q && m_axis_tready) begin
        m_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (acc_d) begin
            m_valid_q <= 1'b1;
            m_data_q  <= s_axis_tdata;
            cnt_q     <= ONE_LEN;
            len_q     <= l_eff_d;
            if (s_axis_tlast) begin
              pkt_done_q <= 1'b1;
              pkt_cnt_q  <= sat_inc(pkt_cnt_q);
              if (l_eff_d != ONE_LEN) begin
                len_err_q   <= 1'b1;
                short_cnt_q <= sat_inc(short_cnt_q);
              end
            end else if (l_eff_d == ONE_LEN) begin
              state_q <= S_DROP;
            end else begin
              state_q <= S_RUN;
            end
          end else begin
            cnt_q <= {CW{1'b0}};
          end
        end
        S_RUN: begin
          if (acc_d) begin
            m_valid_q <= 1'b1;
            m_data_q  <= s_axis_tdata;
            cnt_q     <= cnt_inc_d;
            if (s_axis_tlast) begin
              pkt_done_q <= 1'b1;
              pkt_cnt_q  <= sat_inc(pkt_cnt_q);
              state_q    <= S_IDLE;
              if (cnt_inc_d != len_q) begin
                len_err_q   <= 1'b1;
                short_cnt_q <= sat_inc(short_cnt_q);
              end
            end else if (cnt_inc_d == len_q) begin
              state_q <= S_DROP;
            end
          end
        end
        S_DROP: begin
          // o_cnt already equals the packet length here and simply holds.
          if (acc_d && s_axis_tlast) begin
            pkt_done_q <= 1'b1;
            len_err_q  <= 1'b1;
            pkt_cnt_q  <= sat_inc(pkt_cnt_q);
            long_cnt_q <= sat_inc(long_cnt_q);
            state_q    <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign o_cnt         = cnt_q;
  assign pkt_done      = pkt_done_q;
  assign len_err       = len_err_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign short_cnt     = short_cnt_q;
  assign long_cnt      = long_cnt_q;

endmodule

// File: tb/tb_axis_pkt_deframer.sv
// Bench for axis_pkt_deframer: a packet-level reference model is compared with the DUT
// every cycle, plus literal expectations after each directed scenario.
module tb_axis_pkt_deframer;

  localparam int DW   = 32;
  localparam int MAXL = 256;
  localparam int ECW  = 3;
  localparam int CW   = $clog2(MAXL) + 1;
  localparam int CMAX = (1 << ECW) - 1;

  logic           aclk = 1'b0;
  logic           reset = 1'b1;
  logic [CW-1:0]  pkt_length = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic [DW-1:0]  s_axis_tdata = '0;
  logic           s_axis_tlast = 1'b0;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b1;
  logic [DW-1:0]  m_axis_tdata;
  logic [CW-1:0]  o_cnt;
  logic           pkt_done;
  logic           len_err;
  logic [ECW-1:0] pkt_cnt;
  logic [ECW-1:0] short_cnt;
  logic [ECW-1:0] long_cnt;

  axis_pkt_deframer #(
    .TDATA_WIDTH(DW),
    .MAX_PKT_LENGTH(MAXL),
    .ERR_CNT_WIDTH(ECW)
  ) dut (
    .aclk(aclk),
    .reset(reset),
    .pkt_length(pkt_length),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .o_cnt(o_cnt),
    .pkt_done(pkt_done),
    .len_err(len_err),
    .pkt_cnt(pkt_cnt),
    .short_cnt(short_cnt),
    .long_cnt(long_cnt)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model state (packet-level view)
  bit            have_exp = 1'b0;
  bit            in_pkt = 1'b0;
  int            k_beats = 0;
  int            l_len = 0;
  int            e_cnt = 0, e_pkt = 0, e_short = 0, e_long = 0;
  bit            e_done = 1'b0, e_err = 1'b0, e_mv = 1'b0;
  logic [DW-1:0] sb[$];
  int            beats_out = 0, done_seen = 0, err_seen = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            m_mode = 0;

  function automatic int eff_len(input int pl);
    return (pl == 0 || pl > MAXL) ? MAXL : pl;
  endfunction

  // Sink ready pattern: 0 = always ready, 1 = toggling, else random.
  always @(posedge aclk) begin
    #1;
    case (m_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare process: check registered outputs, then advance the model over the coming edge.
  always @(negedge aclk) begin
    bit mv;
    if (have_exp) begin
      cmp("m_tvalid", m_axis_tvalid, e_mv);
      cmp("o_cnt", o_cnt, e_cnt);
      cmp("pkt_done", pkt_done, e_done);
      cmp("len_err", len_err, e_err);
      cmp("pkt_cnt", pkt_cnt, e_pkt);
      cmp("short_cnt", short_cnt, e_short);
      cmp("long_cnt", long_cnt, e_long);
      if (prev_stall) begin
        cmp("stall_valid", m_axis_tvalid, 1);
        cmp("stall_data", m_axis_tdata, prev_data);
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got data %0d expected no beat", m_axis_tdata);
        end else begin
          cmp("m_tdata", m_axis_tdata, sb.pop_front());
          beats_out++;
        end
      end
      cmp("s_tready", s_axis_tready,
          reset ? 0 : ((in_pkt && k_beats >= l_len) ? 1 : (!e_mv || m_axis_tready)));
    end
    prev_stall = (m_axis_tvalid === 1'b1) && !m_axis_tready && !reset;
    prev_data  = m_axis_tdata;
    if (pkt_done === 1'b1) done_seen++;
    if (len_err === 1'b1) err_seen++;
    if (reset) begin
      in_pkt = 0; k_beats = 0; l_len = 0;
      e_cnt = 0; e_pkt = 0; e_short = 0; e_long = 0;
      e_done = 0; e_err = 0; e_mv = 0;
      sb.delete();
      have_exp = 1'b1;
    end else begin
      mv = e_mv && !m_axis_tready;
      e_done = 0;
      e_err = 0;
      if (s_axis_tvalid && s_axis_tready === 1'b1) begin
        if (!in_pkt) begin
          in_pkt = 1;
          k_beats = 0;
          l_len = eff_len(int'(pkt_length));
        end
        k_beats++;
        if (k_beats <= l_len) begin
          sb.push_back(s_axis_tdata);
          mv = 1;
        end
        e_cnt = (k_beats < l_len) ? k_beats : l_len;
        if (s_axis_tlast) begin
          e_done = 1;
          e_err = (k_beats != l_len);
          if (e_pkt < CMAX) e_pkt++;
          if (k_beats < l_len && e_short < CMAX) e_short++;
          if (k_beats > l_len && e_long < CMAX) e_long++;
          in_pkt = 0;
        end
      end else begin
        e_cnt = in_pkt ? ((k_beats < l_len) ? k_beats : l_len) : 0;
      end
      e_mv = mv;
    end
  end

  task automatic wait_acc(inout int stalls);
    int  t = 0;
    bit  a = 1'b0;
    bit  done = 1'b0;
    while (!done) begin
      @(negedge aclk);
      a = (s_axis_tready === 1'b1);
      @(posedge aclk);
      #1;
      if (a) begin
        done = 1'b1;
      end else begin
        stalls++;
        t++;
        if (t > 1000) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: got no tready after %0d cycles expected acceptance", t);
          done = 1'b1;
        end
      end
    end
  endtask

  // Sends nsend beats of an nbeats-long packet; pkt_length is disturbed after beat 1.
  task automatic send_pkt(input int nbeats, input int plen, input int base, input int nsend,
                          input bit gaps, output int stalls);
    stalls = 0;
    pkt_length = CW'(plen);
    for (int i = 0; i < nsend; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge aclk);
        #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(base + i);
      s_axis_tlast  = (i == nbeats - 1);
      wait_acc(stalls);
      if (i == 0) pkt_length = CW'(plen + 3);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    @(negedge aclk);
    while ((sb.size() != 0 || m_axis_tvalid === 1'b1) && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    cmp("drain_timeout", (t >= 2000), 0);
    repeat (2) @(negedge aclk);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int st, st2, n0, e0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    cmp("rst_tready", s_axis_tready, 0);
    cmp("rst_mvalid", m_axis_tvalid, 0);
    cmp("rst_pkt_cnt", pkt_cnt, 0);
    cmp("rst_o_cnt", o_cnt, 0);
    @(posedge aclk);
    #1;
    reset = 1'b0;

    // 256-beat packet at full length, continuous ready
    n0 = beats_out;
    send_pkt(256, 256, 0, 256, 1'b0, st);
    drain();
    cmp("t1_stalls", st, 0);
    cmp("t1_beats", beats_out - n0, 256);
    cmp("t1_pkt_cnt", pkt_cnt, 1);
    cmp("t1_done_pulses", done_seen, 1);
    cmp("t1_err_pulses", err_seen, 0);

    // short packet: 10 beats against 16
    n0 = beats_out;
    send_pkt(10, 16, 1000, 10, 1'b0, st);
    drain();
    cmp("t2_beats", beats_out - n0, 10);
    cmp("t2_short_cnt", short_cnt, 1);
    cmp("t2_pkt_cnt", pkt_cnt, 2);
    cmp("t2_err_pulses", err_seen, 1);
    cmp("t2_o_cnt_idle", o_cnt, 0);

    // long packet: 20 beats against 16, sink toggling
    m_mode = 1;
    n0 = beats_out;
    send_pkt(20, 16, 2000, 20, 1'b0, st);
    drain();
    cmp("t3_beats", beats_out - n0, 16);
    cmp("t3_long_cnt", long_cnt, 1);
    cmp("t3_pkt_cnt", pkt_cnt, 3);
    cmp("t3_err_pulses", err_seen, 2);

    // 64 beats with source gaps and toggling sink
    n0 = beats_out;
    send_pkt(64, 64, 3000, 64, 1'b1, st);
    drain();
    cmp("t4_beats", beats_out - n0, 64);
    cmp("t4_pkt_cnt", pkt_cnt, 4);
    cmp("t4_err_pulses", err_seen, 2);

    // out-of-range lengths clamp to MAX, back to back
    m_mode = 0;
    n0 = beats_out;
    send_pkt(256, 0, 4000, 256, 1'b0, st);
    send_pkt(256, 300, 5000, 256, 1'b0, st2);
    drain();
    cmp("t5_stalls", st + st2, 0);
    cmp("t5_beats", beats_out - n0, 512);
    cmp("t5_pkt_cnt", pkt_cnt, 6);
    cmp("t5_err_pulses", err_seen, 2);

    // single-beat boundary cases, pushing pkt_cnt into saturation
    n0 = beats_out;
    send_pkt(1, 1, 6000, 1, 1'b0, st);
    send_pkt(3, 1, 6100, 3, 1'b0, st);
    send_pkt(1, 4, 6200, 1, 1'b0, st);
    drain();
    cmp("t6_beats", beats_out - n0, 3);
    cmp("t6_pkt_cnt_sat", pkt_cnt, 7);
    cmp("t6_short_cnt", short_cnt, 2);
    cmp("t6_long_cnt", long_cnt, 2);
    cmp("t6_err_pulses", err_seen, 4);

    // reset in the middle of a packet, then a clean packet
    send_pkt(16, 16, 7000, 5, 1'b0, st);
    reset = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    cmp("t7_rst_mvalid", m_axis_tvalid, 0);
    cmp("t7_rst_pkt_cnt", pkt_cnt, 0);
    cmp("t7_rst_short", short_cnt, 0);
    cmp("t7_rst_long", long_cnt, 0);
    cmp("t7_rst_o_cnt", o_cnt, 0);
    @(posedge aclk);
    #1;
    reset = 1'b0;
    n0 = beats_out;
    e0 = err_seen;
    send_pkt(16, 16, 8000, 16, 1'b0, st);
    drain();
    cmp("t7_beats", beats_out - n0, 16);
    cmp("t7_pkt_cnt", pkt_cnt, 1);
    cmp("t7_err_pulses", err_seen - e0, 0);
    cmp("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
